// File: rtl/audio_fx_pkg.sv
// Shared definitions for the audio effects stage: mode codes, echo pipeline
// states and a width-generic saturating clamp.
package audio_fx_pkg;

  localparam logic [1:0] MODE_MUTE   = 2'd0;
  localparam logic [1:0] MODE_BYPASS = 2'd1;
  localparam logic [1:0] MODE_TONE   = 2'd2;
  localparam logic [1:0] MODE_ECHO   = 2'd3;

  typedef enum logic [1:0] {
    PS_IDLE  = 2'd0,
    PS_READ  = 2'd1,
    PS_WRITE = 2'd2
  } pipe_state_t;

  // Clamp a sign-extended value to the two's complement range of w bits.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] x,
                                                input int unsigned      w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)      sat_to = hi;
    else if (x < lo) sat_to = lo;
    else             sat_to = x;
  endfunction

endpackage

// File: rtl/audio_effects_engine_sine_rom.sv
// Full-cycle sine lookup, amplitude 2^(DATA_W-1)-1, built at elaboration.
module sine_rom #(
  parameter int DATA_W     = 16,
  parameter int TABLE_BITS = 8
) (
  input  logic [TABLE_BITS-1:0] idx,
  output logic [DATA_W-1:0]     data
);

  localparam int  N   = 1 << TABLE_BITS;
  localparam real AMP = 2.0 ** (DATA_W - 1) - 1.0;

  logic [DATA_W-1:0] rom [N];

  for (genvar k = 0; k < N; k++) begin : g_tab
    localparam real R = AMP * $sin(2.0 * 3.14159265358979323846 * k / N);
    // round half away from zero; $rtoi alone truncates
    localparam int  V = (R >= 0.0) ? $rtoi(R + 0.5) : $rtoi(R - 0.5);
    assign rom[k] = V[DATA_W-1:0];
  end

  assign data = rom[idx];

endmodule

// File: rtl/audio_effects_engine.sv
// Codec-side effects stage: mute / bypass / tone / feedback echo, with the
// output source switched only on sample_req so mode changes never glitch.
module audio_effects_engine
  import audio_fx_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int TABLE_BITS = 8,
  parameter int PHASE_W    = 16,
  parameter int DELAY_AW   = 4
) (
  input  logic                audio_clk,
  input  logic                reset_n,
  input  logic                sample_end,
  input  logic                sample_req,
  input  logic [DATA_W-1:0]   audio_input,
  output logic [DATA_W-1:0]   audio_output,
  input  logic [1:0]          mode,
  input  logic [PHASE_W-1:0]  tone_step,
  input  logic [3:0]          tone_atten,
  input  logic [DELAY_AW-1:0] delay_len,
  input  logic [3:0]          decay_shift,
  output logic                overrun
);

  localparam int              DEPTH = 1 << DELAY_AW;
  localparam logic [DELAY_AW:0] FULL = DEPTH[DELAY_AW:0];

  pipe_state_t              state;
  logic signed [DATA_W-1:0] in_reg, echo_reg, rd_data, delayed, echo_next, tone_val;
  logic signed [DATA_W:0]   echo_sum;
  logic signed [63:0]       echo_sat;
  logic [PHASE_W-1:0]       phase;
  logic [DELAY_AW-1:0]      wr_ptr, rd_addr;
  logic [DELAY_AW:0]        fill;
  logic [DATA_W-1:0]        rom_data;
  logic                     start, ram_we;
  logic [DATA_W-1:0]        dly_ram [DEPTH];

  assign start   = sample_end && (state == PS_IDLE);
  assign ram_we  = (state == PS_WRITE);
  assign rd_addr = wr_ptr - delay_len;

  sine_rom #(.DATA_W(DATA_W), .TABLE_BITS(TABLE_BITS)) u_rom (
    .idx  (phase[PHASE_W-1 -: TABLE_BITS]),
    .data (rom_data)
  );

  assign tone_val = $signed(rom_data) >>> tone_atten;

  // Until the line holds delay_len samples the RAM word is stale or undefined.
  always_comb begin
    delayed = '0;
    if (delay_len != '0 && fill >= {1'b0, delay_len})
      delayed = rd_data >>> decay_shift;
    echo_sum  = {in_reg[DATA_W-1], in_reg} + {delayed[DATA_W-1], delayed};
    echo_sat  = sat_to(64'(echo_sum), DATA_W);
    echo_next = echo_sat[DATA_W-1:0];
  end

  always_ff @(posedge audio_clk) begin
    if (ram_we) dly_ram[wr_ptr] <= echo_next;
    if (start)  rd_data <= dly_ram[rd_addr];
  end

  always_ff @(posedge audio_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= PS_IDLE;
      in_reg       <= '0;
      echo_reg     <= '0;
      wr_ptr       <= '0;
      fill         <= '0;
      phase        <= '0;
      audio_output <= '0;
      overrun      <= 1'b0;
    end else begin
      overrun <= sample_end && (state != PS_IDLE);
      case (state)
        PS_IDLE: if (sample_end) begin
          in_reg <= audio_input;
          state  <= PS_READ;
        end
        PS_READ:  state <= PS_WRITE;
        PS_WRITE: begin
          echo_reg <= echo_next;
          wr_ptr   <= wr_ptr + 1'b1;
          if (fill != FULL) fill <= fill + 1'b1;
          state    <= PS_IDLE;
        end
        default: state <= PS_IDLE;
      endcase
      if (sample_req) begin
        phase <= phase + tone_step;
        case (mode)
          MODE_MUTE:   audio_output <= '0;
          MODE_BYPASS: audio_output <= in_reg;
          MODE_TONE:   audio_output <= tone_val;
          default:     audio_output <= echo_reg;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_effects_engine.sv
// Scoreboard bench for audio_effects_engine: requests push expected samples,
// a monitor pops and compares one cycle after each sample_req.
module tb_audio_effects_engine;

  typedef struct {
    logic [15:0] v;
    bit          chk;
  } exp_t;

  logic        audio_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_end = 1'b0, sample_req = 1'b0;
  logic [15:0] audio_input = '0;
  logic [15:0] audio_output;
  logic [1:0]  mode = 2'd0;
  logic [15:0] tone_step = '0;
  logic [3:0]  tone_atten = '0;
  logic [3:0]  delay_len = '0;
  logic [3:0]  decay_shift = '0;
  logic        overrun;

  int   n_chk = 0, n_pass = 0;
  exp_t exp_q[$];
  logic req_d = 1'b0;

  audio_effects_engine #(.DATA_W(16), .TABLE_BITS(8), .PHASE_W(16), .DELAY_AW(4)) dut (
    .audio_clk    (audio_clk),
    .reset_n      (reset_n),
    .sample_end   (sample_end),
    .sample_req   (sample_req),
    .audio_input  (audio_input),
    .audio_output (audio_output),
    .mode         (mode),
    .tone_step    (tone_step),
    .tone_atten   (tone_atten),
    .delay_len    (delay_len),
    .decay_shift  (decay_shift),
    .overrun      (overrun)
  );

  always #5 audio_clk = ~audio_clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: output is valid on the negedge following a sampled sample_req.
  always @(posedge audio_clk) req_d <= sample_req;
  always @(negedge audio_clk) begin
    exp_t e;
    if (req_d) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_output: got %h expected none", audio_output);
      end else begin
        e = exp_q.pop_front();
        if (e.chk) chk("audio_output", audio_output, e.v);
      end
    end
  end

  task automatic tick();
    @(negedge audio_clk);
  endtask

  task automatic send(input logic [15:0] s);
    audio_input = s;
    sample_end  = 1'b1;
    tick();
    sample_end  = 1'b0;
    repeat (3) tick();
  endtask

  task automatic req(input logic [15:0] v, input bit c);
    exp_t e;
    e.v = v;
    e.chk = c;
    exp_q.push_back(e);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    repeat (2) tick();
    chk("reset_output", audio_output, 16'h0000);
    chk("reset_overrun", {15'd0, overrun}, 16'h0000);
    reset_n = 1'b1;
    tick();

    // bypass and mute
    mode = 2'd1;
    send(16'h1234);
    req(16'h1234, 1'b1);
    mode = 2'd0;
    req(16'h0000, 1'b1);

    // reset mid-stream clears the output at once
    mode = 2'd1;
    send(16'h5A5A);
    req(16'h5A5A, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midreset_output", audio_output, 16'h0000);
    chk("midreset_overrun", {15'd0, overrun}, 16'h0000);
    tick();
    reset_n = 1'b1;
    tick();

    // tone, step 0x100: one table entry per request
    mode = 2'd2;
    tone_step = 16'h0100;
    tone_atten = 4'd0;
    for (int i = 0; i <= 256; i++) begin
      case (i)
        0, 128, 256: req(16'h0000, 1'b1);
        64:          req(16'h7FFF, 1'b1);
        192:         req(16'h8001, 1'b1);
        default:     req(16'h0000, 1'b0);
      endcase
    end
    do_reset();
    tone_step = 16'h4000;
    tone_atten = 4'd1;
    req(16'h0000, 1'b1);
    req(16'h3FFF, 1'b1);
    req(16'h0000, 1'b1);
    req(16'hC000, 1'b1);

    // positive saturation
    do_reset();
    mode = 2'd3;
    delay_len = 4'd1;
    decay_shift = 4'd0;
    send(16'h7000); req(16'h7000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      send(16'h7000); req(16'h7FFF, 1'b1);
    end

    // negative saturation
    do_reset();
    send(16'h9000); req(16'h9000, 1'b1);
    send(16'h9000); req(16'h8000, 1'b1);
    send(16'h9000); req(16'h8000, 1'b1);

    // echo impulse, delay 4, halving
    do_reset();
    delay_len = 4'd4;
    decay_shift = 4'd1;
    for (int n = 0; n <= 12; n++) begin
      send(n == 0 ? 16'h4000 : 16'h0000);
      v = ((n % 4) == 0) ? (16'h4000 >> (n / 4)) : 16'h0000;
      req(v, 1'b1);
    end

    // overrun: back-to-back sample_end, second dropped
    mode = 2'd1;
    audio_input = 16'h1111;
    sample_end = 1'b1;
    tick();
    chk("overrun_t1", {15'd0, overrun}, 16'h0000);
    audio_input = 16'h2222;
    tick();
    sample_end = 1'b0;
    chk("overrun_t2", {15'd0, overrun}, 16'h0001);
    tick();
    chk("overrun_t3", {15'd0, overrun}, 16'h0000);
    repeat (2) tick();
    req(16'h1111, 1'b1);

    // simultaneous strobes: old sample out, new captured
    audio_input = 16'h5555;
    exp_q.push_back('{v: 16'h1111, chk: 1'b1});
    sample_end = 1'b1;
    sample_req = 1'b1;
    tick();
    sample_end = 1'b0;
    sample_req = 1'b0;
    repeat (3) tick();
    req(16'h5555, 1'b1);

    repeat (4) tick();
    chk("queue_drain", 16'(exp_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/audio_effects_engine.md
# audio_effects_engine

Parametrised, single-clock audio effects stage that sits between the codec serial interface (which supplies the `sample_end`/`sample_req` strobes) and the DAC data path. It generalises the fixed 16-bit, 100-entry, priority-selected effects block:
- configurable sample width, sine-table size and phase resolution;
- programmable tone frequency and attenuation;
- a feedback echo on a circular delay line, with saturating arithmetic;
- glitch-free mode switching at sample boundaries.

## Interface
Parameters:
- `DATA_W`, 16, sample width (two's complement).
- `TABLE_BITS`, 8, log2 of full-cycle sine table entries.
- `PHASE_W`, 16, phase accumulator width; must be ≥ `TABLE_BITS`.
- `DELAY_AW`, 4, log2 of delay-line depth (`DELAY_DEPTH` = 2^`DELAY_AW`).

Ports:
- `audio_clk` input, 1, sole clock.
- `reset_n` input, 1, asynchronous active-low reset.
- `sample_end` input, 1, one-cycle strobe: `audio_input` is valid.
- `sample_req` input, 1, one-cycle strobe: codec takes the next output.
- `audio_input` input, `DATA_W`, ADC sample.
- `audio_output` output, `DATA_W`, registered DAC sample.
- `mode` input, 2, 0 MUTE, 1 BYPASS, 2 TONE, 3 ECHO.
- `tone_step` input, `PHASE_W`, phase increment per `sample_req`.
- `tone_atten` input, 4, arithmetic right shift applied to the tone.
- `delay_len` input, `DELAY_AW`, echo delay in samples; 0 = echo disabled.
- `decay_shift` input, 4, arithmetic right shift applied to the delayed sample.
- `overrun` output, 1, one-cycle pulse when a `sample_end` is dropped.

## Operation
- **Input capture.** On `sample_end` (pipeline idle): `in_reg` ← `audio_input`; the echo pipeline starts.
- **Echo pipeline**, for a `sample_end` at cycle t:
  - t: issue a synchronous read at `wr_ptr − delay_len` (mod `DELAY_DEPTH`).
  - t+1: read data is valid.
  - t+2: `echo_reg` ← sat(`in_reg` + (delayed >>> `decay_shift`)). The same value is written at `wr_ptr`, which then increments and wraps modulo `DELAY_DEPTH`.
- **Empty-line masking.** The delayed term is forced to 0 when `delay_len` = 0 or `fill` < `delay_len`. `fill` counts writes and saturates at `DELAY_DEPTH`.
- **Echo arithmetic.** The sum is formed at `DATA_W`+1 bits, then clamped to [−2^(`DATA_W`−1), 2^(`DATA_W`−1)−1].
- **Tone.** `phase` is `PHASE_W` bits. The table index is `phase[PHASE_W-1 -: TABLE_BITS]`. Table entry k = round((2^(`DATA_W`−1)−1)·sin(2πk/2^`TABLE_BITS`)).
- **Phase advance.** `phase` += `tone_step` on every `sample_req`, in every mode, so the tone stays phase-continuous across mode changes. Wrap is natural modulo 2^`PHASE_W`.
- **Output select.** `mode` is sampled only on `sample_req`, which makes mode changes glitch-free. Source per mode:
  - MUTE: 0.
  - BYPASS: `in_reg`.
  - TONE: table[index of the pre-increment `phase`] >>> `tone_atten`.
  - ECHO: `echo_reg`.
- **Live inputs.** `delay_len`, `decay_shift`, `tone_step` and `tone_atten` are used live at their point of use. Changing them does not flush the delay line.

## Timing
- **Reset values.** `audio_output`, `in_reg`, `echo_reg`, `phase`, `wr_ptr`, `fill` and the pipeline state are all 0; `overrun` is 0. Delay RAM contents are undefined but masked because `fill` = 0.
- **Reset mid-operation.** An in-flight echo operation is abandoned and no RAM write occurs.
- **Pipeline FSM.** States IDLE → READ → WRITE → IDLE, one cycle each. Entry to READ is on `sample_end` in IDLE only.
- **Overrun.** A `sample_end` in READ or WRITE is ignored and `overrun` pulses on the next cycle.
- **Output latency.** `audio_output` updates exactly 1 cycle after `sample_req`.
- **Simultaneous strobes.** If `sample_end` and `sample_req` fall in the same cycle, the output uses the old `in_reg`/`echo_reg` and the new sample is captured.
- **Echo in flight.** A `sample_req` at t+1 or t+2 of an echo operation sees the previous `echo_reg`.

## Structure
- **Shared package `audio_fx_pkg`:**
  - mode encodings `MODE_MUTE`/`MODE_BYPASS`/`MODE_TONE`/`MODE_ECHO`;
  - pipeline state enum;
  - a saturation function parameterised by width.
- **Sub-module `sine_rom`:**
  - parameters `DATA_W`, `TABLE_BITS`;
  - combinational lookup;
  - table generated at elaboration from the formula above.
- **Delay line:** inferred single-port-write/sync-read RAM inside the top block.

## Test plan
Bench parameters: `DATA_W`=16, `TABLE_BITS`=8, `PHASE_W`=16, `DELAY_AW`=4.

1. **Reset.** Assert `reset_n`=0 mid-stream → `audio_output`=0x0000 and `overrun`=0 immediately. The first echo after release has delayed term 0.
2. **BYPASS.** `sample_end` with input 0x1234, then `sample_req` → `audio_output`=0x1234 one cycle later. With MUTE selected the output is 0x0000.
3. **TONE.** `tone_step`=0x0100, `tone_atten`=0:
   - request 0 → 0x0000; request 64 → 0x7FFF; request 128 → 0x0000; request 192 → 0x8001;
   - request 256 repeats request 0.
   - With `tone_atten`=1, request 64 → 0x3FFF.
4. **ECHO impulse.** `delay_len`=4, `decay_shift`=1; input 0x4000 then zeros → outputs 0x4000 at sample 0, 0x2000 at 4, 0x1000 at 8, 0x0800 at 12.
5. **Saturation.** `delay_len`=1, `decay_shift`=0:
   - constant input 0x7000 → sample 1 = 0x7FFF (clamped), held.
   - constant input 0x9000 → 0x8000.
6. **Overrun and collision.**
   - `sample_end` at cycles t and t+1 → second dropped, `overrun` high at t+2 only.
   - `sample_end` and `sample_req` in the same cycle → output shows the prior sample.
